vending_controller: RTL

VENDING_CONTROLLER -- requirements
Module: vending_controller

---
 rtl/vending_controller.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vending_controller.sv
// Vending controller: coin credit, vend handshake with an external item dispenser,
// timed/requested change return. Optional per-item stock counters under STOCK_COUNT_EN.

module vending_item_slot #(
    parameter int                    TOTAL_BITS = 14,
    parameter logic [TOTAL_BITS-1:0] PRICE      = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  credit,
    input  logic [TOTAL_BITS-1:0] balance,
    input  logic                  vend,
    output logic                  available
);
`ifdef STOCK_COUNT_EN
    logic [2:0] stock;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      stock <= 3'd3;
        else if (vend && stock != 3'd0) stock <= stock - 3'd1;
    end

    assign available = credit && (balance >= PRICE) && (stock != 3'd0);
`else
    logic unused_slot;
    assign unused_slot = ^{clk, reset, vend};
    assign available   = credit && (balance >= PRICE);
`endif
endmodule

module vending_controller #(
    parameter int NUM_COINS  = 3,
    parameter int NUM_ITEMS  = 4,
    parameter int TOTAL_BITS = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_COINS-1:0]  i_input_coin,
    input  logic [NUM_ITEMS-1:0]  i_select_item,
    input  logic                  i_trigger_return,
    output logic [NUM_ITEMS-1:0]  disp_select,
    output logic [NUM_ITEMS-1:0]  disp_available,
    output logic [TOTAL_BITS-1:0] disp_balance,
    input  logic [NUM_ITEMS-1:0]  disp_output_item,
    input  logic [TOTAL_BITS-1:0] disp_item_cost,
    output logic [NUM_ITEMS-1:0]  o_available_item,
    output logic [NUM_ITEMS-1:0]  o_output_item,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic [NUM_COINS-1:0]  o_reject_coin,
    output logic [TOTAL_BITS-1:0] o_balance,
    output logic                  o_busy
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CREDIT = 2'd1;
    localparam logic [1:0] ST_VEND   = 2'd2;
    localparam logic [1:0] ST_CHANGE = 2'd3;

    localparam logic [3:0]            K_WAIT  = 4'd10;
    localparam logic [TOTAL_BITS:0]   MAX_BAL = (TOTAL_BITS+1)'(9900);
    // Coin values must stay ascending: change selection keeps the last fitting coin.
    localparam logic [TOTAL_BITS-1:0] COIN_VAL [NUM_COINS] =
        '{TOTAL_BITS'(100), TOTAL_BITS'(500), TOTAL_BITS'(1000)};
    localparam logic [TOTAL_BITS-1:0] ITEM_PRICE [NUM_ITEMS] =
        '{TOTAL_BITS'(400), TOTAL_BITS'(500), TOTAL_BITS'(1000), TOTAL_BITS'(2000)};

    logic [1:0]            state;
    logic [3:0]            timer;
    logic [TOTAL_BITS-1:0] balance;
    logic [TOTAL_BITS-1:0] coin_sum, base_bal, chg_val;
    logic [TOTAL_BITS:0]   sum_ext;
    logic [NUM_COINS-1:0]  chg_coin;
    logic                  coin_phase, coin_any, coin_reject, coin_accept;
    logic                  leave_credit, vend_go;

    always_comb begin
        coin_sum = '0;
        chg_coin = '0;
        chg_val  = '0;
        for (int c = 0; c < NUM_COINS; c++) begin
            if (i_input_coin[c]) coin_sum = coin_sum + COIN_VAL[c];
            if (balance >= COIN_VAL[c]) begin
                chg_coin    = '0;
                chg_coin[c] = 1'b1;
                chg_val     = COIN_VAL[c];
            end
        end
    end

    // Return request or timeout outranks a same-cycle vend grant.
    assign leave_credit = (state == ST_CREDIT) && (i_trigger_return || timer == 4'd0);
    assign vend_go      = (state == ST_CREDIT) && !leave_credit && (disp_output_item != '0);
    assign base_bal     = vend_go ? balance - disp_item_cost : balance;
    assign sum_ext      = {1'b0, base_bal} + {1'b0, coin_sum};
    assign coin_phase   = (state != ST_CHANGE);
    assign coin_any     = coin_phase && (i_input_coin != '0);
    assign coin_reject  = coin_any && (sum_ext > MAX_BAL);
    assign coin_accept  = coin_any && !coin_reject;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            balance       <= '0;
            timer         <= '0;
            o_output_item <= '0;
            o_return_coin <= '0;
            o_reject_coin <= '0;
        end else begin
            o_output_item <= '0;
            o_return_coin <= '0;
            o_reject_coin <= coin_reject ? i_input_coin : '0;
            if (coin_phase)
                balance <= coin_accept ? sum_ext[TOTAL_BITS-1:0] : base_bal;
            case (state)
                ST_IDLE: begin
                    if (coin_accept) begin
                        state <= ST_CREDIT;
                        timer <= K_WAIT;
                    end
                end
                ST_CREDIT: begin
                    if (leave_credit) begin
                        state <= ST_CHANGE;
                    end else if (vend_go) begin
                        state         <= ST_VEND;
                        o_output_item <= disp_output_item;
                        timer         <= K_WAIT;
                    end else if (coin_accept) begin
                        timer <= K_WAIT;
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                ST_VEND: begin
                    state <= ST_CREDIT;
                    if (coin_accept) timer <= K_WAIT;
                end
                ST_CHANGE: begin
                    if (balance == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        o_return_coin <= chg_coin;
                        balance       <= balance - chg_val;
                        if (balance == chg_val) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_slot
        vending_item_slot #(
            .TOTAL_BITS (TOTAL_BITS),
            .PRICE      (ITEM_PRICE[i])
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .credit    (state == ST_CREDIT),
            .balance   (balance),
            .vend      (vend_go && disp_output_item[i]),
            .available (o_available_item[i])
        );
    end

    assign o_balance      = balance;
    assign o_busy         = (state == ST_VEND) || (state == ST_CHANGE);
    assign disp_select    = (state == ST_CREDIT) ? i_select_item : '0;
    assign disp_available = o_available_item;
    assign disp_balance   = balance;
endmodule
